// File: rtl/sonar_rx_pkg.sv
// Shared encodings and constants for the sonar serial receiver (7O1 link, "AAA,DDD#" frames).
// Optional odd-parity checking is enabled by defining SONAR_RX_PARITY_EN.
package sonar_rx_pkg;

  typedef enum logic [3:0] {
    INICIAL = 4'd0,
    A0      = 4'd1,
    A1      = 4'd2,
    A2      = 4'd3,
    VIRG    = 4'd4,
    D0      = 4'd5,
    D1      = 4'd6,
    D2      = 4'd7,
    FIM     = 4'd8
  } estado_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PAR,
    RX_STOP
  } rx_estado_t;

  localparam logic [6:0] ASCII_VIRG = 7'h2C;
  localparam logic [6:0] ASCII_FIM  = 7'h23;
  localparam logic [6:0] ASCII_0    = 7'h30;

  localparam int BAUD_DIV_DEF = 434;
  localparam int TIMEOUT_DEF  = 2500000;

  function automatic logic is_digito(input logic [6:0] c);
    return (c >= ASCII_0) && (c <= ASCII_0 + 7'd9);
  endfunction

endpackage

// File: rtl/rx_serial_7o1.sv
// 7O1 UART receiver: 2-flop line sync, mid-bit sampling, false-start rejection.
// SONAR_RX_PARITY_EN defined: odd parity checked; otherwise the parity bit is ignored.
module rx_serial_7o1
  import sonar_rx_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       entrada_serial,
  output logic [6:0] dado,
  output logic       dado_valido,
  output logic       erro_quadro
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);

  rx_estado_t    estado_q, estado_d;
  logic          sync1_q, sync1_d, sync2_q, sync2_d, lin_q, lin_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bits_q, bits_d;
  logic [6:0]    shift_q, shift_d, dado_q, dado_d;
  logic          par_ok_q, par_ok_d, valido_q, valido_d, erro_q, erro_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q <= RX_IDLE;
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      lin_q    <= 1'b1;
      cnt_q    <= '0;
      bits_q   <= '0;
      shift_q  <= '0;
      dado_q   <= '0;
      par_ok_q <= 1'b0;
      valido_q <= 1'b0;
      erro_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      lin_q    <= lin_d;
      cnt_q    <= cnt_d;
      bits_q   <= bits_d;
      shift_q  <= shift_d;
      dado_q   <= dado_d;
      par_ok_q <= par_ok_d;
      valido_q <= valido_d;
      erro_q   <= erro_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    sync1_d  = entrada_serial;
    sync2_d  = sync1_q;
    lin_d    = sync2_q;
    cnt_d    = cnt_q;
    bits_d   = bits_q;
    shift_d  = shift_q;
    dado_d   = dado_q;
    par_ok_d = par_ok_q;
    valido_d = 1'b0;
    erro_d   = 1'b0;
    case (estado_q)
      RX_IDLE: begin
        cnt_d = '0;
        // a genuine start needs a high-to-low transition, so a low line after a bad stop is not re-read
        if (lin_q && !sync2_q) estado_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF) begin
          cnt_d    = '0;
          bits_d   = '0;
          estado_d = sync2_q ? RX_IDLE : RX_DATA;
        end else cnt_d = cnt_q + CW'(1);
      end
      RX_DATA: begin
        if (cnt_q == FULL) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[6:1]};
          bits_d  = bits_q + 3'd1;
          if (bits_q == 3'd6) estado_d = RX_PAR;
        end else cnt_d = cnt_q + CW'(1);
      end
      RX_PAR: begin
        if (cnt_q == FULL) begin
          cnt_d    = '0;
`ifdef SONAR_RX_PARITY_EN
          par_ok_d = ^{shift_q, sync2_q};
`else
          par_ok_d = 1'b1;
`endif
          estado_d = RX_STOP;
        end else cnt_d = cnt_q + CW'(1);
      end
      RX_STOP: begin
        if (cnt_q == FULL) begin
          cnt_d    = '0;
          dado_d   = shift_q;
          valido_d = 1'b1;
          erro_d   = !sync2_q || !par_ok_q;
          estado_d = RX_IDLE;
        end else cnt_d = cnt_q + CW'(1);
      end
      default: estado_d = RX_IDLE;
    endcase
  end

  assign dado        = dado_q;
  assign dado_valido = valido_q;
  assign erro_quadro = erro_q;

endmodule

// File: rtl/sonar_rx_medida.sv
// Sonar link receiver top: parses "AAA,DDD#" into BCD angle/distance with pronto/erro pulses.
// Parity checking in the character receiver is enabled by defining SONAR_RX_PARITY_EN.
module sonar_rx_medida
  import sonar_rx_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        entrada_serial,
  output logic [11:0] angulo,
  output logic [11:0] distancia,
  output logic        pronto,
  output logic        erro,
  output logic [3:0]  db_estado
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  logic [6:0] dado;
  logic       dado_valido, erro_quadro;

  rx_serial_7o1 #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clock         (clock),
    .reset         (reset),
    .entrada_serial(entrada_serial),
    .dado          (dado),
    .dado_valido   (dado_valido),
    .erro_quadro   (erro_quadro)
  );

  estado_t       estado_q, estado_d;
  logic [11:0]   sh_ang_q, sh_ang_d, sh_dist_q, sh_dist_d;
  logic [11:0]   ang_q, ang_d, dist_q, dist_d;
  logic          pronto_q, pronto_d, erro_q, erro_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          espera_digito, aceita;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q  <= INICIAL;
      sh_ang_q  <= '0;
      sh_dist_q <= '0;
      ang_q     <= '0;
      dist_q    <= '0;
      pronto_q  <= 1'b0;
      erro_q    <= 1'b0;
      tmo_q     <= '0;
    end else begin
      estado_q  <= estado_d;
      sh_ang_q  <= sh_ang_d;
      sh_dist_q <= sh_dist_d;
      ang_q     <= ang_d;
      dist_q    <= dist_d;
      pronto_q  <= pronto_d;
      erro_q    <= erro_d;
      tmo_q     <= tmo_d;
    end
  end

  always_comb begin
    estado_d  = estado_q;
    sh_ang_d  = sh_ang_q;
    sh_dist_d = sh_dist_q;
    ang_d     = ang_q;
    dist_d    = dist_q;
    pronto_d  = 1'b0;
    erro_d    = 1'b0;
    espera_digito = (estado_q != A2) && (estado_q != D2);
    aceita = !erro_quadro &&
             (espera_digito ? is_digito(dado)
                            : (dado == ((estado_q == A2) ? ASCII_VIRG : ASCII_FIM)));
    if (estado_q == INICIAL || estado_q == FIM || dado_valido) tmo_d = '0;
    else tmo_d = tmo_q + TW'(1);

    case (estado_q)
      FIM: begin
        ang_d    = sh_ang_q;
        dist_d   = sh_dist_q;
        pronto_d = 1'b1;
        estado_d = INICIAL;
      end
      default: begin
        if (dado_valido) begin
          // a stray '#' while idle is just the tail of a frame we joined late
          if (estado_q == INICIAL && !erro_quadro && dado == ASCII_FIM) begin
            estado_d = INICIAL;
          end else if (aceita) begin
            estado_d = estado_t'(estado_q + 4'd1);
            case (estado_q)
              INICIAL: sh_ang_d[11:8]  = dado[3:0];
              A0:      sh_ang_d[7:4]   = dado[3:0];
              A1:      sh_ang_d[3:0]   = dado[3:0];
              VIRG:    sh_dist_d[11:8] = dado[3:0];
              D0:      sh_dist_d[7:4]  = dado[3:0];
              D1:      sh_dist_d[3:0]  = dado[3:0];
              default: ;
            endcase
          end else begin
            erro_d   = 1'b1;
            estado_d = INICIAL;
          end
        end else if (estado_q != INICIAL && tmo_q == TMAX) begin
          erro_d   = 1'b1;
          estado_d = INICIAL;
        end
      end
    endcase
  end

  assign angulo    = ang_q;
  assign distancia = dist_q;
  assign pronto    = pronto_q;
  assign erro      = erro_q;
  assign db_estado = estado_q;

endmodule

// File: tb/tb_sonar_rx_medida.sv
// Self-checking bench for sonar_rx_medida: directed scenarios plus randomized frames vs a frame model.
module tb_sonar_rx_medida;

  localparam int BD  = 8;
  localparam int TMO = 300;

  logic        clock = 1'b0;
  logic        rst = 1'b0;
  logic        rx = 1'b1;
  logic [11:0] angulo, distancia;
  logic        pronto, erro;
  logic [3:0]  db_estado;

  always #5 clock = ~clock;

  sonar_rx_medida #(.BAUD_DIV(BD), .TIMEOUT(TMO)) dut (
    .clock         (clock),
    .reset         (rst),
    .entrada_serial(rx),
    .angulo        (angulo),
    .distancia     (distancia),
    .pronto        (pronto),
    .erro          (erro),
    .db_estado     (db_estado)
  );

  int n_err = 0;
  int n_chk = 0;

  // observed events
  logic [11:0] q_ang[$];
  logic [11:0] q_dist[$];
  int n_erro = 0;
  int n_both = 0;

  always @(negedge clock) begin
    if (pronto) begin
      q_ang.push_back(angulo);
      q_dist.push_back(distancia);
    end
    if (erro) n_erro++;
    if (pronto && erro) n_both++;
  end

  // frame model: list of accepted characters, validated by position in "AAA,DDD#"
  logic [6:0]  m_buf[8];
  int          m_n = 0;
  logic [11:0] m_ang = '0;
  logic [11:0] m_dist = '0;
  logic [11:0] e_ang[$];
  logic [11:0] e_dist[$];
  int          e_erro = 0;

  function automatic void model_char(input logic [6:0] c, input bit bad);
    bit isd;
    bit ok;
    isd = (c >= 7'h30) && (c <= 7'h39);
    if (m_n == 0 && !bad && c == 7'h23) return;
    if (m_n == 3)      ok = !bad && (c == 7'h2C);
    else if (m_n == 7) ok = !bad && (c == 7'h23);
    else               ok = !bad && isd;
    if (!ok) begin
      e_erro++;
      m_n = 0;
      return;
    end
    m_buf[m_n] = c;
    m_n++;
    if (m_n == 8) begin
      m_ang  = 100 * (m_buf[0] - 7'h30) + 10 * (m_buf[1] - 7'h30) + (m_buf[2] - 7'h30);
      m_dist = 100 * (m_buf[4] - 7'h30) + 10 * (m_buf[5] - 7'h30) + (m_buf[6] - 7'h30);
      // decimal value -> BCD digits
      m_ang  = {4'(m_ang / 100), 4'((m_ang / 10) % 10), 4'(m_ang % 10)};
      m_dist = {4'(m_dist / 100), 4'((m_dist / 10) % 10), 4'(m_dist % 10)};
      e_ang.push_back(m_ang);
      e_dist.push_back(m_dist);
      m_n = 0;
    end
  endfunction

  task automatic clear_obs();
    q_ang.delete();
    q_dist.delete();
    e_ang.delete();
    e_dist.delete();
    n_erro = 0;
    e_erro = 0;
  endtask

  task automatic send_char(input logic [6:0] c, input bit bad_par, input bit bad_stop);
    logic [9:0] fr;
    bit bad;
`ifdef SONAR_RX_PARITY_EN
    bad = bad_par || bad_stop;
`else
    bad = bad_stop;
`endif
    model_char(c, bad);
    fr = {~bad_stop, (~^c) ^ bad_par, c, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = fr[i];
      repeat (BD) @(negedge clock);
    end
    rx = 1'b1;
    repeat (2 * BD) @(negedge clock);
  endtask

  task automatic send_str(input string s);
    byte b;
    for (int i = 0; i < s.len(); i++) begin
      b = s[i];
      send_char(b[6:0], 1'b0, 1'b0);
    end
  endtask

  task automatic settle();
    repeat (20) @(negedge clock);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clock);
    n_chk++; if (angulo !== 12'h000) begin n_err++; $display("FAIL reset_angulo got=%h want=000", angulo); end
    n_chk++; if (distancia !== 12'h000) begin n_err++; $display("FAIL reset_distancia got=%h want=000", distancia); end
    n_chk++; if (pronto !== 1'b0) begin n_err++; $display("FAIL reset_pronto got=%b want=0", pronto); end
    n_chk++; if (erro !== 1'b0) begin n_err++; $display("FAIL reset_erro got=%b want=0", erro); end
    n_chk++; if (db_estado !== 4'd0) begin n_err++; $display("FAIL reset_db_estado got=%0d want=0", db_estado); end
    rst = 1'b1;
    repeat (3) @(negedge clock);
    $display("reset: done");
  endtask

  task automatic test_frame();
    clear_obs();
    send_str("090,123#");
    settle();
    n_chk++; if (q_ang.size() !== 1) begin n_err++; $display("FAIL frame_pronto_count got=%0d want=1", q_ang.size()); end
    n_chk++; if (angulo !== 12'h090) begin n_err++; $display("FAIL frame_angulo got=%h want=090", angulo); end
    n_chk++; if (distancia !== 12'h123) begin n_err++; $display("FAIL frame_distancia got=%h want=123", distancia); end
    n_chk++; if (n_erro !== 0) begin n_err++; $display("FAIL frame_erro_count got=%0d want=0", n_erro); end
    $display("frame 090,123#: angulo=%h distancia=%h prontos=%0d", angulo, distancia, q_ang.size());
  endtask

  task automatic test_bad_char();
    clear_obs();
    send_str("09X,123#");
    settle();
    n_chk++; if (q_ang.size() !== 0) begin n_err++; $display("FAIL badchar_pronto_count got=%0d want=0", q_ang.size()); end
    n_chk++; if (n_erro !== e_erro) begin n_err++; $display("FAIL badchar_erro_count got=%0d want=%0d", n_erro, e_erro); end
    n_chk++; if (angulo !== 12'h090) begin n_err++; $display("FAIL badchar_angulo got=%h want=090", angulo); end
    n_chk++; if (distancia !== 12'h123) begin n_err++; $display("FAIL badchar_distancia got=%h want=123", distancia); end
    n_chk++; if (db_estado !== 4'(m_n)) begin n_err++; $display("FAIL badchar_db_estado got=%0d want=%0d", db_estado, m_n); end
    $display("frame 09X,123#: erros=%0d prontos=%0d", n_erro, q_ang.size());
  endtask

  task automatic test_glitch();
    clear_obs();
    rx = 1'b0;
    repeat (2) @(negedge clock);
    rx = 1'b1;
    repeat (40) @(negedge clock);
    n_chk++; if (n_erro !== 0) begin n_err++; $display("FAIL glitch_erro got=%0d want=0", n_erro); end
    n_chk++; if (db_estado !== 4'd0) begin n_err++; $display("FAIL glitch_db_estado got=%0d want=0", db_estado); end
    send_str("180,005#");
    settle();
    n_chk++; if (q_ang.size() !== 1) begin n_err++; $display("FAIL glitch_pronto_count got=%0d want=1", q_ang.size()); end
    n_chk++; if (angulo !== 12'h180) begin n_err++; $display("FAIL glitch_angulo got=%h want=180", angulo); end
    n_chk++; if (distancia !== 12'h005) begin n_err++; $display("FAIL glitch_distancia got=%h want=005", distancia); end
    $display("glitch then 180,005#: angulo=%h distancia=%h erros=%0d", angulo, distancia, n_erro);
  endtask

  task automatic test_timeout();
    clear_obs();
    send_str("045,02");
    settle();
    n_chk++; if (db_estado !== 4'd6) begin n_err++; $display("FAIL timeout_partial_state got=%0d want=6", db_estado); end
    n_chk++; if (n_erro !== 0) begin n_err++; $display("FAIL timeout_early_erro got=%0d want=0", n_erro); end
    repeat (TMO + 20) @(negedge clock);
    e_erro++;
    m_n = 0;
    n_chk++; if (n_erro !== e_erro) begin n_err++; $display("FAIL timeout_erro got=%0d want=%0d", n_erro, e_erro); end
    n_chk++; if (db_estado !== 4'd0) begin n_err++; $display("FAIL timeout_db_estado got=%0d want=0", db_estado); end
    n_chk++; if (angulo !== 12'h180 || distancia !== 12'h005) begin
      n_err++; $display("FAIL timeout_outputs got=%h/%h want=180/005", angulo, distancia);
    end
    $display("timeout after 045,02: erros=%0d db_estado=%0d", n_erro, db_estado);
  endtask

  task automatic test_parity();
    clear_obs();
    send_str("000,00");
    send_char(7'h33, 1'b1, 1'b0);
    send_str("#");
    settle();
    n_chk++; if (q_ang.size() !== e_ang.size()) begin n_err++; $display("FAIL parity_pronto_count got=%0d want=%0d", q_ang.size(), e_ang.size()); end
    n_chk++; if (n_erro !== e_erro) begin n_err++; $display("FAIL parity_erro_count got=%0d want=%0d", n_erro, e_erro); end
    n_chk++; if (angulo !== m_ang || distancia !== m_dist) begin
      n_err++; $display("FAIL parity_outputs got=%h/%h want=%h/%h", angulo, distancia, m_ang, m_dist);
    end
    $display("parity-corrupt 000,003#: erros=%0d prontos=%0d angulo=%h distancia=%h", n_erro, q_ang.size(), angulo, distancia);
  endtask

  task automatic test_reset_mid();
    clear_obs();
    send_str("123,45");
    n_chk++; if (db_estado !== 4'd6) begin n_err++; $display("FAIL resetmid_state got=%0d want=6", db_estado); end
    rst = 1'b0;
    #1;
    n_chk++; if (angulo !== 12'h000 || distancia !== 12'h000) begin
      n_err++; $display("FAIL resetmid_outputs got=%h/%h want=000/000", angulo, distancia);
    end
    n_chk++; if (db_estado !== 4'd0) begin n_err++; $display("FAIL resetmid_db_estado got=%0d want=0", db_estado); end
    m_n = 0; m_ang = '0; m_dist = '0;
    repeat (3) @(negedge clock);
    rst = 1'b1;
    repeat (3) @(negedge clock);
    clear_obs();
    send_str("321,654#");
    settle();
    n_chk++; if (angulo !== 12'h321 || distancia !== 12'h654) begin
      n_err++; $display("FAIL resetmid_next_frame got=%h/%h want=321/654", angulo, distancia);
    end
    n_chk++; if (q_ang.size() !== 1) begin n_err++; $display("FAIL resetmid_pronto_count got=%0d want=1", q_ang.size()); end
    $display("reset mid-frame then 321,654#: angulo=%h distancia=%h", angulo, distancia);
  endtask

  task automatic test_random();
    logic [6:0] fr[8];
    int pos_bad, pos_stop, pos_par;
    for (int r = 0; r < 8; r++) begin
      clear_obs();
      for (int i = 0; i < 8; i++) fr[i] = 7'h30 + 7'($urandom_range(0, 9));
      fr[3] = 7'h2C;
      fr[7] = 7'h23;
      pos_bad  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
      pos_stop = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 7)) : -1;
      pos_par  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 7)) : -1;
      if (pos_bad >= 0) fr[pos_bad] = 7'($urandom_range(32, 126));
      if ($urandom_range(0, 3) == 0) send_char(7'h23, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) send_char(fr[i], i == pos_par, i == pos_stop);
      settle();
      n_chk++; if (q_ang.size() !== e_ang.size()) begin
        n_err++; $display("FAIL rand%0d_pronto_count got=%0d want=%0d", r, q_ang.size(), e_ang.size());
      end
      for (int i = 0; i < q_ang.size() && i < e_ang.size(); i++) begin
        n_chk++; if (q_ang[i] !== e_ang[i] || q_dist[i] !== e_dist[i]) begin
          n_err++; $display("FAIL rand%0d_frame got=%h/%h want=%h/%h", r, q_ang[i], q_dist[i], e_ang[i], e_dist[i]);
        end
      end
      n_chk++; if (n_erro !== e_erro) begin n_err++; $display("FAIL rand%0d_erro_count got=%0d want=%0d", r, n_erro, e_erro); end
      n_chk++; if (angulo !== m_ang || distancia !== m_dist) begin
        n_err++; $display("FAIL rand%0d_outputs got=%h/%h want=%h/%h", r, angulo, distancia, m_ang, m_dist);
      end
      n_chk++; if (db_estado !== 4'(m_n)) begin n_err++; $display("FAIL rand%0d_db_estado got=%0d want=%0d", r, db_estado, m_n); end
      $display("random %0d: chars=%s prontos=%0d erros=%0d angulo=%h distancia=%h",
               r, {fr[0], fr[1], fr[2], fr[3], fr[4], fr[5], fr[6], fr[7]}, q_ang.size(), n_erro, angulo, distancia);
    end
    n_chk++; if (n_both !== 0) begin n_err++; $display("FAIL pronto_erro_overlap got=%0d want=0", n_both); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_bad_char();
    test_glitch();
    test_timeout();
    test_parity();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
